// File: rtl/flash_ctrl_pkg.sv
// Shared definitions for the parallel-flash read controller: FSM state encoding
// and elaboration-time sizing helpers.
package flash_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_TURN   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic int clog2_int(input int value);
    int bits;
    int span;
    bits = 0;
    span = 1;
    while (span < value) begin
      span = span * 2;
      bits = bits + 1;
    end
    return bits;
  endfunction

  function automatic int lane_count(input int bus_dw, input int flash_dw);
    return bus_dw / flash_dw;
  endfunction

  // Width of a counter/index holding 0..n-1; never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? clog2_int(n) : 1;
  endfunction

endpackage

// File: rtl/flash_wait_timer.sv
// Load/count-down timer; expired is high once the count has reached zero,
// so a load value of K gives K+1 cycles until expiry.
module flash_wait_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/flash_read_ctrl.sv
// Reads one BUS_DW word from a parallel flash as N little-endian FLASH_DW lane
// reads with a programmable access time and inter-lane turnaround.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | cs_n/oe_n low on base+lane for WAIT_CYCLES, lane sampled at the end
// TURN   | cs_n/oe_n high for TURN_CYCLES between lane reads
// RESP   | assembled word held on rsp_data until rsp_ready
module flash_read_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int FLASH_DW    = 8,
  parameter int BUS_DW      = 32,
  parameter int WAIT_CYCLES = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [BUS_DW-1:0]   rsp_data,
  output logic [ADDR_W-1:0]   flash_address,
  input  logic [FLASH_DW-1:0] flash_data,
  output logic                flash_cs_n,
  output logic                flash_oe_n,
  output logic                flash_we_n
);

  localparam int N       = lane_count(BUS_DW, FLASH_DW);
  localparam int LB      = clog2_int(N);
  localparam int LANE_W  = idx_bits(N);
  localparam int TMR_MAX = (WAIT_CYCLES > TURN_CYCLES) ? WAIT_CYCLES : TURN_CYCLES;
  localparam int TMR_W   = idx_bits(TMR_MAX);

  localparam logic [TMR_W-1:0]  WAIT_LD    = TMR_W'(WAIT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TURN_LD    = TMR_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << LB) - ADDR_W'(1));
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(N - 1);

  if ((BUS_DW % FLASH_DW) != 0 || BUS_DW < FLASH_DW) begin : g_bad_width
    $error("flash_read_ctrl: BUS_DW must be a non-zero multiple of FLASH_DW");
  end
  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("flash_read_ctrl: WAIT_CYCLES must be at least 1");
  end
  if (TURN_CYCLES < 0) begin : g_bad_turn
    $error("flash_read_ctrl: TURN_CYCLES must not be negative");
  end

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BUS_DW-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic                sel_n_q, sel_n_d;
  logic                timer_load;
  logic [TMR_W-1:0]    timer_val;
  logic                timer_expired;

  flash_wait_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    lane_d     = lane_q;
    data_d     = data_q;
    timer_load = 1'b0;
    timer_val  = WAIT_LD;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          base_d     = req_addr & ALIGN_MASK;
          lane_d     = '0;
          state_d    = ST_ACCESS;
          timer_load = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (timer_expired) begin
          data_d[lane_q*FLASH_DW +: FLASH_DW] = flash_data;
          if (lane_q == LAST_LANE) begin
            state_d = ST_RESP;
          end else begin
            lane_d     = lane_q + LANE_W'(1);
            timer_load = 1'b1;
            if (TURN_CYCLES > 0) begin
              state_d   = ST_TURN;
              timer_val = TURN_LD;
            end else begin
              state_d = ST_ACCESS;
            end
          end
        end
      end
      ST_TURN: begin
        if (timer_expired) begin
          state_d    = ST_ACCESS;
          timer_load = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
    sel_n_d = (state_d != ST_ACCESS);
    addr_d  = (state_d == ST_ACCESS) ? base_d + ADDR_W'(lane_d) : addr_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      lane_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      sel_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      sel_n_q <= sel_n_d;
    end
  end

  assign req_ready     = ready_q;
  assign rsp_valid     = valid_q;
  assign rsp_data      = data_q;
  assign flash_address = addr_q;
  assign flash_cs_n    = sel_n_q;
  assign flash_oe_n    = sel_n_q;
  assign flash_we_n    = 1'b1;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Scoreboard bench for flash_read_ctrl: random and directed reads on a default
// instance, plus directed runs on a 64-bit instance and a zero-turnaround instance.
module tb_flash_read_ctrl;

  localparam int AW = 23;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: word is the little-endian concatenation of mem[base+i] = (base+i)[7:0].
  function automatic logic [63:0] model_word(input logic [AW-1:0] addr, input int lanes);
    logic [AW-1:0] base;
    logic [AW-1:0] a;
    logic [63:0]   w;
    w    = '0;
    base = addr - AW'(int'(addr) % lanes);
    for (int i = 0; i < lanes; i++) begin
      a = base + AW'(i);
      w[i*8 +: 8] = a[7:0];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- instance A: defaults ----------------
  logic          rst_a, rv_a, rr_a, sv_a, sr_a, cs_a, oe_a, we_a;
  logic [AW-1:0] ra_a, fa_a;
  logic [31:0]   sd_a;
  wire  [7:0]    fd_a;
  assign fd_a = (!cs_a && !oe_a) ? fa_a[7:0] : 8'hzz;

  flash_read_ctrl dut_a (
    .clock(clock), .reset_n(rst_a), .req_valid(rv_a), .req_ready(rr_a), .req_addr(ra_a),
    .rsp_valid(sv_a), .rsp_ready(sr_a), .rsp_data(sd_a), .flash_address(fa_a),
    .flash_data(fd_a), .flash_cs_n(cs_a), .flash_oe_n(oe_a), .flash_we_n(we_a)
  );

  typedef struct {
    logic [31:0]   word;
    logic [AW-1:0] base;
    int            acc_edge;
  } exp_t;
  exp_t exp_q[$];

  // monitor state
  int            pulses[$];
  int            run_a = 0;
  logic          prev_valid = 1'b0;
  logic          prev_cs = 1'b1;
  logic          hs_prev = 1'b0;
  logic [31:0]   prev_data = '0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clock) begin
    if (!rst_a) begin
      run_a      = 0;
      pulses.delete();
      prev_valid = 1'b0;
      prev_cs    = 1'b1;
      hs_prev    = 1'b0;
      prev_addr  = fa_a;
    end else begin
      check("we_n_high", we_a, 1);
      check("oe_n_follows_access", oe_a, cs_a);
      if (!cs_a) begin
        run_a++;
        if (exp_q.size() > 0)
          check("flash_address", fa_a, exp_q[0].base + AW'(pulses.size()));
      end else begin
        if (run_a > 0) begin
          pulses.push_back(run_a);
          run_a = 0;
        end
        if (prev_cs) check("address_hold", fa_a, prev_addr);
      end
      if (sv_a) check("req_ready_low_in_resp", rr_a, 0);
      if (hs_prev) begin
        check("idle_rsp_valid_cleared", sv_a, 0);
        check("idle_req_ready", rr_a, 1);
      end
      if (sv_a && prev_valid) check("rsp_data_stable", sd_a, prev_data);
      if (sv_a && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", sv_a, 0);
        end else begin
          check("rsp_data", sd_a, exp_q[0].word);
          check("latency", cyc - exp_q[0].acc_edge + 1, 1 + 4*4 + 3*1);
          check("cs_pulse_count", pulses.size(), 4);
          foreach (pulses[i]) check("cs_pulse_len", pulses[i], 4);
          pulses.delete();
        end
      end
      hs_prev = sv_a && sr_a;
      if (hs_prev && exp_q.size() > 0) void'(exp_q.pop_front());
      prev_valid = sv_a;
      prev_data  = sd_a;
      prev_cs    = cs_a;
      prev_addr  = fa_a;
    end
  end

  task automatic issue_a(input logic [AW-1:0] addr);
    int   k;
    exp_t e;
    logic [63:0] w;
    rv_a = 1'b1;
    ra_a = addr;
    k = 0;
    while (rr_a !== 1'b1 && k < 100) begin tick(); k++; end
    if (k >= 100) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: req_ready not seen, addr 0x%0h", addr);
    end
    w          = model_word(addr, 4);
    e.word     = w[31:0];
    e.base     = addr & ~AW'(3);
    e.acc_edge = cyc + 1;
    exp_q.push_back(e);
    tick();
    rv_a = 1'b0;
    ra_a = AW'($urandom);
  endtask

  task automatic txn_a(input logic [AW-1:0] addr, input int stall);
    int k;
    issue_a(addr);
    k = 0;
    while (sv_a !== 1'b1 && k < 200) begin tick(); k++; end
    if (k >= 200) begin
      n_vec++; n_err++;
      $display("FAIL rsp_timeout: rsp_valid not seen, addr 0x%0h", addr);
      exp_q.delete();
    end
    repeat (stall) tick();
    sr_a = 1'b1;
    tick();
    sr_a = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  logic done_a = 1'b0;
  logic [AW-1:0] dir_addr [4] = '{AW'('h10), AW'('h13), AW'('h7FFFFF), AW'('h0)};

  initial begin
    int k;
    logic [AW-1:0] a;
    rst_a = 1'b0; rv_a = 1'b0; sr_a = 1'b0; ra_a = '0;
    repeat (3) tick();
    check("rst_cs_n", cs_a, 1);
    check("rst_oe_n", oe_a, 1);
    check("rst_we_n", we_a, 1);
    check("rst_address", fa_a, 0);
    check("rst_rsp_valid", sv_a, 0);
    check("rst_rsp_data", sd_a, 0);
    check("rst_req_ready", rr_a, 0);
    rst_a = 1'b1;
    check("ready_before_first_edge", rr_a, 0);
    tick();
    check("ready_after_first_edge", rr_a, 1);

    foreach (dir_addr[i]) txn_a(dir_addr[i], 0);
    txn_a(AW'('h123456), 10);
    for (int i = 0; i < 25; i++) txn_a(AW'($urandom), $urandom_range(0, 3));

    // reset in the middle of the third lane's access
    a = AW'($urandom) & ~AW'(3);
    issue_a(a);
    k = 0;
    while (!(cs_a === 1'b0 && fa_a === a + AW'(2)) && k < 100) begin tick(); k++; end
    check("reached_lane2", fa_a, a + AW'(2));
    tick();
    #2 rst_a = 1'b0;
    #1;
    check("async_release_cs_n", cs_a, 1);
    check("async_release_oe_n", oe_a, 1);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_rsp_during_reset", sv_a, 0);
    end
    rst_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_rsp_after_reset", sv_a, 0);
    end
    txn_a(AW'($urandom), 1);
    txn_a(AW'('h000013), 0);
    done_a = 1'b1;
  end

  // ---------------- instance B: 64-bit word ----------------
  logic          rst_b, rv_b, rr_b, sv_b, sr_b, cs_b, oe_b, we_b;
  logic [AW-1:0] ra_b, fa_b;
  logic [63:0]   sd_b;
  wire  [7:0]    fd_b;
  assign fd_b = (!cs_b && !oe_b) ? fa_b[7:0] : 8'hzz;

  flash_read_ctrl #(.BUS_DW(64)) dut_b (
    .clock(clock), .reset_n(rst_b), .req_valid(rv_b), .req_ready(rr_b), .req_addr(ra_b),
    .rsp_valid(sv_b), .rsp_ready(sr_b), .rsp_data(sd_b), .flash_address(fa_b),
    .flash_data(fd_b), .flash_cs_n(cs_b), .flash_oe_n(oe_b), .flash_we_n(we_b)
  );

  int   falls_b = 0;
  logic pcs_b = 1'b1;
  always @(negedge clock) begin
    if (!cs_b && pcs_b) falls_b++;
    pcs_b = cs_b;
  end

  logic done_b = 1'b0;
  initial begin
    int k, acc;
    rst_b = 1'b0; rv_b = 1'b0; sr_b = 1'b0; ra_b = '0;
    repeat (2) tick();
    rst_b = 1'b1;
    tick();
    rv_b = 1'b1;
    ra_b = AW'('h7FFFFC);
    k = 0;
    while (rr_b !== 1'b1 && k < 50) begin tick(); k++; end
    acc = cyc + 1;
    falls_b = 0;
    tick();
    rv_b = 1'b0;
    k = 0;
    while (sv_b !== 1'b1 && k < 200) begin tick(); k++; end
    check("b_rsp_seen", sv_b, 1);
    check("b_rsp_data", sd_b, model_word(AW'('h7FFFFC), 8));
    check("b_latency", cyc - acc + 1, 1 + 8*4 + 7*1);
    check("b_cs_pulses", falls_b, 8);
    check("b_we_n", we_b, 1);
    sr_b = 1'b1;
    tick();
    sr_b = 1'b0;
    check("b_idle_valid", sv_b, 0);
    check("b_idle_ready", rr_b, 1);
    done_b = 1'b1;
  end

  // ---------------- instance C: WAIT=1, TURN=0 ----------------
  logic          rst_c, rv_c, rr_c, sv_c, sr_c, cs_c, oe_c, we_c;
  logic [AW-1:0] ra_c, fa_c;
  logic [31:0]   sd_c;
  wire  [7:0]    fd_c;
  assign fd_c = (!cs_c && !oe_c) ? fa_c[7:0] : 8'hzz;

  flash_read_ctrl #(.WAIT_CYCLES(1), .TURN_CYCLES(0)) dut_c (
    .clock(clock), .reset_n(rst_c), .req_valid(rv_c), .req_ready(rr_c), .req_addr(ra_c),
    .rsp_valid(sv_c), .rsp_ready(sr_c), .rsp_data(sd_c), .flash_address(fa_c),
    .flash_data(fd_c), .flash_cs_n(cs_c), .flash_oe_n(oe_c), .flash_we_n(we_c)
  );

  int   falls_c = 0;
  int   low_c = 0;
  logic pcs_c = 1'b1;
  always @(negedge clock) begin
    if (!cs_c) low_c++;
    if (!cs_c && pcs_c) falls_c++;
    pcs_c = cs_c;
  end

  logic done_c = 1'b0;
  initial begin
    int k, acc;
    logic [63:0] w;
    rst_c = 1'b0; rv_c = 1'b0; sr_c = 1'b0; ra_c = '0;
    repeat (2) tick();
    rst_c = 1'b1;
    tick();
    rv_c = 1'b1;
    ra_c = AW'('h25);
    k = 0;
    while (rr_c !== 1'b1 && k < 50) begin tick(); k++; end
    acc = cyc + 1;
    falls_c = 0;
    low_c = 0;
    tick();
    rv_c = 1'b0;
    k = 0;
    while (sv_c !== 1'b1 && k < 100) begin tick(); k++; end
    w = model_word(AW'('h25), 4);
    check("c_rsp_seen", sv_c, 1);
    check("c_rsp_data", sd_c, w[31:0]);
    check("c_latency", cyc - acc + 1, 5);
    check("c_cs_single_pulse", falls_c, 1);
    check("c_cs_low_cycles", low_c, 4);
    sr_c = 1'b1;
    tick();
    sr_c = 1'b0;
    check("c_idle_ready", rr_c, 1);
    done_c = 1'b1;
  end

  // ---------------- end of run ----------------
  initial begin
    int k;
    k = 0;
    while (!(done_a && done_b && done_c) && k < 20000) begin tick(); k++; end
    if (k >= 20000) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: drivers done a=%0b b=%0b c=%0b", done_a, done_b, done_c);
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
